// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_flags #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4,
   parameter int AF_LEVEL  = (1 << ADDR_SIZE) - 2,
   parameter int AE_LEVEL  = 2,
   parameter int FWFT      = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 winc,
   input  logic [DATA_SIZE-1:0] wdata,
   output logic                 wfull,
   output logic                 almost_full,
   input  logic                 rinc,
   output logic [DATA_SIZE-1:0] rdata,
   output logic                 rempty,
   output logic                 almost_empty,
   output logic [ADDR_SIZE:0]   count,
   input  logic                 err_clr,
   output logic                 wovf,
   output logic                 runf
);

   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] ONE_C   = (ADDR_SIZE+1)'(1);
   localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
   localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(AF_LEVEL);
   localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(AE_LEVEL);

   generate
      if (DATA_SIZE < 1 || ADDR_SIZE < 1 ||
          AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
          AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1 ||
          AE_LEVEL >= AF_LEVEL) begin : g_bad_params
         $error("sync_fifo_flags: illegal parameters (need 0<=AE_LEVEL<AF_LEVEL<=DEPTH)");
      end
   endgenerate

   logic [DATA_SIZE-1:0] r_mem [DEPTH];
   logic [ADDR_SIZE:0]   r_wptr;
   logic [ADDR_SIZE:0]   r_rptr;
   logic [ADDR_SIZE:0]   r_count;
   logic                 r_wfull;
   logic                 r_rempty;
   logic                 r_afull;
   logic                 r_aempty;
   logic                 r_wovf;
   logic                 r_runf;

   logic                 w_wr_acc;
   logic                 w_rd_acc;
   logic [ADDR_SIZE:0]   w_count_nxt;
   logic [ADDR_SIZE:0]   w_ptr_diff;

   // Acceptance uses the registered (pre-edge) flags, so at full a
   // simultaneous write is refused and at empty a simultaneous read is refused.
   assign w_wr_acc   = winc && !r_wfull;
   assign w_rd_acc   = rinc && !r_rempty;
   assign w_ptr_diff = r_wptr - r_rptr;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + ONE_C;
         2'b01:   w_count_nxt = r_count - ONE_C;
         default: w_count_nxt = r_count;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_wfull  <= 1'b0;
         r_rempty <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + ONE_C;
         if (w_rd_acc) r_rptr <= r_rptr + ONE_C;
         r_count  <= w_count_nxt;
         r_wfull  <= (w_count_nxt == DEPTH_C);
         r_rempty <= (w_count_nxt == '0);
         r_afull  <= (w_count_nxt >= AF_C);
         r_aempty <= (w_count_nxt <= AE_C);
      end
   end

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wovf <= 1'b0;
         r_runf <= 1'b0;
      end else begin
         if (winc && r_wfull)  r_wovf <= 1'b1;
         else if (err_clr)     r_wovf <= 1'b0;
         if (rinc && r_rempty) r_runf <= 1'b1;
         else if (err_clr)     r_runf <= 1'b0;
      end
   end

   // NOTE: storage has no reset; only pointers and flags define validity, letting it map to RAM.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wptr[ADDR_SIZE-1:0]] <= wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry is presented directly; only meaningful while !rempty.
         assign rdata = r_mem[r_rptr[ADDR_SIZE-1:0]];
      end else begin : g_reg_read
         logic [DATA_SIZE-1:0] r_rdata;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)           r_rdata <= '0;
            else if (w_rd_acc) r_rdata <= r_mem[r_rptr[ADDR_SIZE-1:0]];
         end
         assign rdata = r_rdata;
      end
   endgenerate

   assign wfull        = r_wfull;
   assign rempty       = r_rempty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign count        = r_count;
   assign wovf         = r_wovf;
   assign runf         = r_runf;

   a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst)
      !(r_wfull && r_rempty));
   a_count_in_range: assert property (@(posedge clk) disable iff (rst)
      r_count <= DEPTH_C);
   a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
      r_count == w_ptr_diff);

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: registered-read instance plus an FWFT instance,
// with a queue scoreboard for the wrap and simultaneous-access sequences.
module tb_sync_fifo_flags;

   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          wfull, almost_full, rempty, almost_empty, wovf, runf;
   logic [DW-1:0] rdata;
   logic [AW:0]   count;

   logic          fw_winc = 1'b0, fw_rinc = 1'b0, fw_err_clr = 1'b0;
   logic [DW-1:0] fw_wdata = '0;
   logic          fw_wfull, fw_afull, fw_rempty, fw_aempty, fw_wovf, fw_runf;
   logic [DW-1:0] fw_rdata;
   logic [AW:0]   fw_count;

   int n_checks = 0;
   int n_fail   = 0;

   sync_fifo_flags #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(0)) u_dut (
      .clk(clk), .rst(rst),
      .winc(winc), .wdata(wdata), .wfull(wfull), .almost_full(almost_full),
      .rinc(rinc), .rdata(rdata), .rempty(rempty), .almost_empty(almost_empty),
      .count(count), .err_clr(err_clr), .wovf(wovf), .runf(runf)
   );

   sync_fifo_flags #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(1)) u_dut_fw (
      .clk(clk), .rst(rst),
      .winc(fw_winc), .wdata(fw_wdata), .wfull(fw_wfull), .almost_full(fw_afull),
      .rinc(fw_rinc), .rdata(fw_rdata), .rempty(fw_rempty), .almost_empty(fw_aempty),
      .count(fw_count), .err_clr(fw_err_clr), .wovf(fw_wovf), .runf(fw_runf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus on the registered-read instance; returns 1 ns after the edge.
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
      winc = w; wdata = d; rinc = r;
      @(posedge clk); #1;
      winc = 1'b0; rinc = 1'b0;
   endtask

   task automatic fcyc(input logic w, input logic [DW-1:0] d, input logic r);
      fw_winc = w; fw_wdata = d; fw_rinc = r;
      @(posedge clk); #1;
      fw_winc = 1'b0; fw_rinc = 1'b0;
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] q [$];
      logic [DW-1:0] exp_d;
      logic          w, r;
      int            cnt;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("por_rempty", 32'(rempty), 32'(1));
      check("por_count",  32'(count),  32'(0));

      // Reset: dirty the state first, then assert rst between clock edges.
      cyc(1'b0, 8'h00, 1'b1);
      check("t1_runf_set", 32'(runf), 32'(1));
      cyc(1'b1, 8'h33, 1'b0);
      cyc(1'b1, 8'h44, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      check("t1_rdata_pre", 32'(rdata), 32'h33);
      check("t1_count_pre", 32'(count), 32'(1));
      #2 rst = 1'b1;
      #1;
      check("t1_rst_count",  32'(count),        32'(0));
      check("t1_rst_rempty", 32'(rempty),       32'(1));
      check("t1_rst_aempty", 32'(almost_empty), 32'(1));
      check("t1_rst_wfull",  32'(wfull),        32'(0));
      check("t1_rst_afull",  32'(almost_full),  32'(0));
      check("t1_rst_rdata",  32'(rdata),        32'(0));
      check("t1_rst_runf",   32'(runf),         32'(0));
      check("t1_rst_wovf",   32'(wovf),         32'(0));
      #1 rst = 1'b0;

      // Fill 0x00..0x0F, then one write too many.
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         check($sformatf("t2_count%0d", i),  32'(count),        32'(i + 1));
         check($sformatf("t2_afull%0d", i),  32'(almost_full),  32'(i + 1 >= 14));
         check($sformatf("t2_wfull%0d", i),  32'(wfull),        32'(i + 1 == 16));
         check($sformatf("t2_aempty%0d", i), 32'(almost_empty), 32'(i + 1 <= 2));
         check($sformatf("t2_rempty%0d", i), 32'(rempty),       32'(0));
      end
      cyc(1'b1, 8'hEE, 1'b0);
      check("t2_wovf",      32'(wovf),  32'(1));
      check("t2_count_ovf", 32'(count), 32'(16));

      // Drain with registered read, then one read too many.
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
         check($sformatf("t3_rdata%0d", i), 32'(rdata), 32'(i));
         check($sformatf("t3_count%0d", i), 32'(count), 32'(15 - i));
      end
      check("t3_rempty", 32'(rempty), 32'(1));
      cyc(1'b0, 8'h00, 1'b1);
      check("t3_runf",       32'(runf),  32'(1));
      check("t3_wovf_held",  32'(wovf),  32'(1));
      check("t3_rdata_hold", 32'(rdata), 32'h0F);
      clear_errors();
      check("t3_wovf_clr", 32'(wovf), 32'(0));
      check("t3_runf_clr", 32'(runf), 32'(0));
      check("t3_wptr_msb", 32'(u_dut.r_wptr), 32'(16));
      check("t3_rptr_msb", 32'(u_dut.r_rptr), 32'(16));

      // Wrap: prefill 4, then interleave so occupancy stays in 4..5.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'(8'h40 + i), 1'b0);
         q.push_back(8'(8'h40 + i));
      end
      cnt = 4;
      for (int k = 0; k < 40; k++) begin
         w = (k % 4 != 2);
         r = (k % 4 != 0);
         cyc(w, 8'(8'h50 + k), r);
         if (r) begin
            exp_d = q.pop_front();
            check($sformatf("t4_rdata%0d", k), 32'(rdata), 32'(exp_d));
         end
         if (w) q.push_back(8'(8'h50 + k));
         cnt = cnt + int'(w) - int'(r);
         check($sformatf("t4_count%0d", k), 32'(count), 32'(cnt));
      end
      check("t4_wptr_wrapped", 32'(u_dut.r_wptr), 32'(18));
      check("t4_rptr_wrapped", 32'(u_dut.r_rptr), 32'(14));

      // Simultaneous access at full, then at empty.
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 8'(8'h80 + i), 1'b0);
         q.push_back(8'(8'h80 + i));
      end
      check("t5_full", 32'(wfull), 32'(1));
      cyc(1'b1, 8'hFF, 1'b1);
      exp_d = q.pop_front();
      check("t5_full_rdata", 32'(rdata),       32'(exp_d));
      check("t5_full_count", 32'(count),       32'(15));
      check("t5_full_wovf",  32'(wovf),        32'(1));
      check("t5_full_wfull", 32'(wfull),       32'(0));
      check("t5_full_afull", 32'(almost_full), 32'(1));
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
         exp_d = q.pop_front();
         check($sformatf("t5_drain%0d", i), 32'(rdata), 32'(exp_d));
      end
      check("t5_drained", 32'(rempty), 32'(1));
      clear_errors();
      cyc(1'b1, 8'h5A, 1'b1);
      check("t5_empty_count",  32'(count),        32'(1));
      check("t5_empty_runf",   32'(runf),         32'(1));
      check("t5_empty_wovf",   32'(wovf),         32'(0));
      check("t5_empty_rempty", 32'(rempty),       32'(0));
      check("t5_empty_aempty", 32'(almost_empty), 32'(1));
      cyc(1'b0, 8'h00, 1'b1);
      check("t5_empty_rdata", 32'(rdata), 32'h5A);
      check("t5_final_count", 32'(count), 32'(0));

      // First-word-fall-through instance.
      check("t6_init_rempty", 32'(fw_rempty), 32'(1));
      fcyc(1'b1, 8'hA5, 1'b0);
      check("t6_rempty",  32'(fw_rempty), 32'(0));
      check("t6_rdata",   32'(fw_rdata),  32'hA5);
      check("t6_count",   32'(fw_count),  32'(1));
      fcyc(1'b1, 8'h3C, 1'b0);
      check("t6_rdata_head", 32'(fw_rdata), 32'hA5);
      fcyc(1'b0, 8'h00, 1'b1);
      check("t6_rdata_next", 32'(fw_rdata),  32'h3C);
      check("t6_rempty_mid", 32'(fw_rempty), 32'(0));
      fcyc(1'b0, 8'h00, 1'b1);
      check("t6_rempty_end", 32'(fw_rempty), 32'(1));
      check("t6_count_end",  32'(fw_count),  32'(0));
      check("t6_aempty",     32'(fw_aempty), 32'(1));
      check("t6_afull",      32'(fw_afull),  32'(0));
      check("t6_wfull",      32'(fw_wfull),  32'(0));
      check("t6_wovf",       32'(fw_wovf),   32'(0));
      check("t6_runf",       32'(fw_runf),   32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
